// File: rtl/mc_control_unit.sv
// mc_control_unit: multi-cycle CPU control FSM (IF->ID->EXE->MEM->WB).
// Optional feature macro: MC_JAL_EN. When it is defined, jal links $31 in ID.
// When it is undefined, jal decodes as an illegal no-op.
// Nine states need a 4-bit state register.
module mc_control_unit #(
  parameter int unsigned OP_W    = 6,
  parameter int unsigned ALUOP_W = 3
) (
  input  logic               CLK,
  input  logic               Reset,
  input  logic [OP_W-1:0]    op,
  input  logic               zero,
  input  logic               sign,
  output logic               PCWre,
  output logic               IRWre,
  output logic               RegWre,
  output logic [1:0]         RegDst,
  output logic               WrRegDSrc,
  output logic               ALUSrcA,
  output logic               ALUSrcB,
  output logic               ExtSel,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic               mRD,
  output logic               mWR,
  output logic               DBDataSrc,
  output logic [1:0]         PCSrc
);

  localparam int unsigned STATE_W = 4;

  localparam logic [OP_W-1:0] OP_ADD   = OP_W'(6'b000000);
  localparam logic [OP_W-1:0] OP_SUB   = OP_W'(6'b000001);
  localparam logic [OP_W-1:0] OP_ADDIU = OP_W'(6'b000010);
  localparam logic [OP_W-1:0] OP_AND   = OP_W'(6'b010000);
  localparam logic [OP_W-1:0] OP_ANDI  = OP_W'(6'b010001);
  localparam logic [OP_W-1:0] OP_ORI   = OP_W'(6'b010010);
  localparam logic [OP_W-1:0] OP_XORI  = OP_W'(6'b010011);
  localparam logic [OP_W-1:0] OP_SLL   = OP_W'(6'b011000);
  localparam logic [OP_W-1:0] OP_SLT   = OP_W'(6'b100110);
  localparam logic [OP_W-1:0] OP_SLTI  = OP_W'(6'b100111);
  localparam logic [OP_W-1:0] OP_SW    = OP_W'(6'b110000);
  localparam logic [OP_W-1:0] OP_LW    = OP_W'(6'b110001);
  localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(6'b110100);
  localparam logic [OP_W-1:0] OP_BNE   = OP_W'(6'b110101);
  localparam logic [OP_W-1:0] OP_BLTZ  = OP_W'(6'b110110);
  localparam logic [OP_W-1:0] OP_J     = OP_W'(6'b111000);
  localparam logic [OP_W-1:0] OP_JR    = OP_W'(6'b111001);
`ifdef MC_JAL_EN
  localparam logic [OP_W-1:0] OP_JAL   = OP_W'(6'b111010);
`endif
  localparam logic [OP_W-1:0] OP_HALT  = OP_W'(6'b111111);

  localparam logic [ALUOP_W-1:0] ALU_ADD = ALUOP_W'(3'b000);
  localparam logic [ALUOP_W-1:0] ALU_SUB = ALUOP_W'(3'b001);
  localparam logic [ALUOP_W-1:0] ALU_SLL = ALUOP_W'(3'b010);
  localparam logic [ALUOP_W-1:0] ALU_OR  = ALUOP_W'(3'b011);
  localparam logic [ALUOP_W-1:0] ALU_AND = ALUOP_W'(3'b100);
  localparam logic [ALUOP_W-1:0] ALU_SLT = ALUOP_W'(3'b101);
  localparam logic [ALUOP_W-1:0] ALU_XOR = ALUOP_W'(3'b110);

  typedef enum logic [STATE_W-1:0] {
    S_IF, S_ID, S_EXE_AL, S_EXE_BR, S_EXE_MEM, S_MEM, S_WB_AL, S_WB_LW, S_HALT
  } state_t;

  state_t state;

  logic               isAlu, isIType, isBranch, isMem, isLw, isHalt, isJ, isJr, isJal, isLegal;
  logic               decSrcA, decSrcB, decExt, brTaken;
  logic [ALUOP_W-1:0] decAluOp;

  // Opcode decode: instruction class and datapath controls for EXE..WB
  always_comb begin
    isAlu    = 1'b0;
    isIType  = 1'b0;
    isBranch = 1'b0;
    isMem    = 1'b0;
    isLw     = 1'b0;
    isHalt   = 1'b0;
    isJ      = 1'b0;
    isJr     = 1'b0;
    isJal    = 1'b0;
    decSrcA  = 1'b0;
    decSrcB  = 1'b0;
    decExt   = 1'b0;
    decAluOp = ALU_ADD;
    brTaken  = 1'b0;
    case (op)
      OP_ADD:   begin isAlu = 1'b1; end
      OP_SUB:   begin isAlu = 1'b1; decAluOp = ALU_SUB; end
      OP_ADDIU: begin isAlu = 1'b1; isIType = 1'b1; decSrcB = 1'b1; decExt = 1'b1; end
      OP_AND:   begin isAlu = 1'b1; decAluOp = ALU_AND; end
      OP_ANDI:  begin isAlu = 1'b1; isIType = 1'b1; decSrcB = 1'b1; decAluOp = ALU_AND; end
      OP_ORI:   begin isAlu = 1'b1; isIType = 1'b1; decSrcB = 1'b1; decAluOp = ALU_OR; end
      OP_XORI:  begin isAlu = 1'b1; isIType = 1'b1; decSrcB = 1'b1; decAluOp = ALU_XOR; end
      OP_SLL:   begin isAlu = 1'b1; decSrcA = 1'b1; decAluOp = ALU_SLL; end
      OP_SLT:   begin isAlu = 1'b1; decAluOp = ALU_SLT; end
      OP_SLTI:  begin isAlu = 1'b1; isIType = 1'b1; decSrcB = 1'b1; decExt = 1'b1;
                      decAluOp = ALU_SLT; end
      OP_SW:    begin isMem = 1'b1; decSrcB = 1'b1; decExt = 1'b1; end
      OP_LW:    begin isMem = 1'b1; isLw = 1'b1; decSrcB = 1'b1; decExt = 1'b1; end
      OP_BEQ:   begin isBranch = 1'b1; decExt = 1'b1; decAluOp = ALU_SUB; brTaken = zero; end
      OP_BNE:   begin isBranch = 1'b1; decExt = 1'b1; decAluOp = ALU_SUB; brTaken = ~zero; end
      OP_BLTZ:  begin isBranch = 1'b1; decAluOp = ALU_SUB; brTaken = sign; end
      OP_J:     begin isJ = 1'b1; end
      OP_JR:    begin isJr = 1'b1; end
`ifdef MC_JAL_EN
      OP_JAL:   begin isJal = 1'b1; end
`endif
      OP_HALT:  begin isHalt = 1'b1; end
      default:  ;
    endcase
    isLegal = isAlu | isBranch | isMem | isHalt | isJ | isJr | isJal;
  end

  // State sequencing; synchronous reset returns to fetch and aborts any instruction
  always_ff @(posedge CLK) begin
    if (!Reset) begin
      state <= S_IF;
    end else begin
      case (state)
        S_IF:      state <= S_ID;
        S_ID: begin
          if (isBranch)   state <= S_EXE_BR;
          else if (isMem) state <= S_EXE_MEM;
          else if (isHalt) state <= S_HALT;
          else if (isAlu) state <= S_EXE_AL;
          else            state <= S_IF;
        end
        S_EXE_AL:  state <= S_WB_AL;
        S_EXE_BR:  state <= S_IF;
        S_EXE_MEM: state <= S_MEM;
        S_MEM:     state <= isLw ? S_WB_LW : S_IF;
        S_WB_AL:   state <= S_IF;
        S_WB_LW:   state <= S_IF;
        S_HALT:    state <= S_HALT;
        default:   state <= S_IF;
      endcase
    end
  end

  // Output decode from state and opcode; everything is held low while Reset is low
  always_comb begin
    PCWre     = 1'b0;
    IRWre     = 1'b0;
    RegWre    = 1'b0;
    RegDst    = 2'b00;
    WrRegDSrc = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 1'b0;
    ExtSel    = 1'b0;
    ALUOp     = ALU_ADD;
    mRD       = 1'b0;
    mWR       = 1'b0;
    DBDataSrc = 1'b0;
    PCSrc     = 2'b00;
    if (Reset) begin
      case (state)
        S_IF: IRWre = 1'b1;
        S_ID: begin
          if (isJ) begin
            PCWre = 1'b1; PCSrc = 2'b11;
          end else if (isJr) begin
            PCWre = 1'b1; PCSrc = 2'b10;
          end else if (isJal) begin
            PCWre = 1'b1; PCSrc = 2'b11; RegWre = 1'b1; RegDst = 2'b00; WrRegDSrc = 1'b0;
          end else if (!isLegal) begin
            PCWre = 1'b1; PCSrc = 2'b00;
          end
        end
        S_EXE_BR: begin
          ExtSel = decExt;
          ALUOp  = ALU_SUB;
          PCWre  = 1'b1;
          PCSrc  = brTaken ? 2'b01 : 2'b00;
        end
        S_EXE_AL, S_EXE_MEM, S_MEM, S_WB_AL, S_WB_LW: begin
          ALUSrcA = decSrcA;
          ALUSrcB = decSrcB;
          ExtSel  = decExt;
          ALUOp   = decAluOp;
          if (state == S_MEM) begin
            mRD   = isLw;
            mWR   = ~isLw;
            PCWre = ~isLw;
          end
          if (state == S_WB_AL) begin
            RegWre    = 1'b1;
            WrRegDSrc = 1'b1;
            RegDst    = isIType ? 2'b01 : 2'b10;
            PCWre     = 1'b1;
          end
          if (state == S_WB_LW) begin
            RegWre    = 1'b1;
            RegDst    = 2'b01;
            WrRegDSrc = 1'b1;
            DBDataSrc = 1'b1;
            mRD       = 1'b1;
            PCWre     = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_control_unit.sv
// Directed testbench for mc_control_unit; expected controls are hand-computed per cycle.
// Expectations for jal follow the MC_JAL_EN macro.
module tb_mc_control_unit;

  logic       CLK = 1'b0;
  logic       Reset;
  logic [5:0] op;
  logic       zero, sign;
  logic       PCWre, IRWre, RegWre, WrRegDSrc, ALUSrcA, ALUSrcB, ExtSel, mRD, mWR, DBDataSrc;
  logic [1:0] RegDst, PCSrc;
  logic [2:0] ALUOp;

  int errors = 0;
  int checks = 0;

  mc_control_unit dut (
    .CLK(CLK), .Reset(Reset), .op(op), .zero(zero), .sign(sign),
    .PCWre(PCWre), .IRWre(IRWre), .RegWre(RegWre), .RegDst(RegDst),
    .WrRegDSrc(WrRegDSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ExtSel(ExtSel),
    .ALUOp(ALUOp), .mRD(mRD), .mWR(mWR), .DBDataSrc(DBDataSrc), .PCSrc(PCSrc)
  );

  always #5 CLK = ~CLK;

  logic [16:0] obs;
  assign obs = {PCWre, IRWre, RegWre, RegDst, WrRegDSrc, ALUSrcA, ALUSrcB, ExtSel,
                ALUOp, mRD, mWR, DBDataSrc, PCSrc};

  // Pack one expected control word: pcw irw rw rd wr a b x alu mr mw db pcs
  function automatic logic [16:0] e(input logic pcw, input logic irw, input logic rw,
                                    input logic [1:0] rd, input logic wr, input logic a,
                                    input logic b, input logic x, input logic [2:0] alu,
                                    input logic mr, input logic mw, input logic db,
                                    input logic [1:0] pcs);
    return {pcw, irw, rw, rd, wr, a, b, x, alu, mr, mw, db, pcs};
  endfunction

  localparam logic [16:0] ZERO = 17'h0;
  localparam logic [16:0] IFX  = 17'h08000;

  task automatic chk(input string tag, input logic [16:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%05h expected=%05h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Watchdog so the run always ends
  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    Reset = 1'b0; op = 6'b000000; zero = 1'b0; sign = 1'b0;
    tick(); tick();
    chk("reset_hold", ZERO);
    Reset = 1'b1; #1;
    chk("reset_release_if", IFX);

    // add: RegWre only in cycle 4, RegDst=10
    op = 6'b000000;
    tick(); chk("add_id", ZERO);
    tick(); chk("add_exe", ZERO);
    tick(); chk("add_wb", e(1,0,1,2'b10,1,0,0,0,3'b000,0,0,0,2'b00));
    tick(); chk("add_next_if", IFX);

    // ori: I-type, zero-extend, OR
    op = 6'b010010;
    tick(); chk("ori_id", ZERO);
    tick(); chk("ori_exe", e(0,0,0,2'b00,0,0,1,0,3'b011,0,0,0,2'b00));
    tick(); chk("ori_wb", e(1,0,1,2'b01,1,0,1,0,3'b011,0,0,0,2'b00));
    tick(); chk("ori_next_if", IFX);

    // sll: shift amount on A, R-type destination
    op = 6'b011000;
    tick(); tick(); chk("sll_exe", e(0,0,0,2'b00,0,1,0,0,3'b010,0,0,0,2'b00));
    tick(); chk("sll_wb", e(1,0,1,2'b10,1,1,0,0,3'b010,0,0,0,2'b00));
    tick();

    // slti: sign-extend, signed compare
    op = 6'b100111;
    tick(); tick(); chk("slti_exe", e(0,0,0,2'b00,0,0,1,1,3'b101,0,0,0,2'b00));
    tick(); chk("slti_wb", e(1,0,1,2'b01,1,0,1,1,3'b101,0,0,0,2'b00));
    tick();

    // lw: mRD in cycles 4-5, RegWre only in cycle 5
    op = 6'b110001;
    tick(); chk("lw_id", ZERO);
    tick(); chk("lw_exe", e(0,0,0,2'b00,0,0,1,1,3'b000,0,0,0,2'b00));
    tick(); chk("lw_mem", e(0,0,0,2'b00,0,0,1,1,3'b000,1,0,0,2'b00));
    tick(); chk("lw_wb", e(1,0,1,2'b01,1,0,1,1,3'b000,1,0,1,2'b00));
    tick(); chk("lw_next_if", IFX);

    // sw: mWR only in cycle 4, no RegWre
    op = 6'b110000;
    tick(); tick(); chk("sw_exe", e(0,0,0,2'b00,0,0,1,1,3'b000,0,0,0,2'b00));
    tick(); chk("sw_mem", e(1,0,0,2'b00,0,0,1,1,3'b000,0,1,0,2'b00));
    tick(); chk("sw_next_if", IFX);

    // branches resolve in cycle 3
    op = 6'b110100; zero = 1'b1;
    tick(); tick(); chk("beq_taken", e(1,0,0,2'b00,0,0,0,1,3'b001,0,0,0,2'b01));
    tick(); chk("beq_next_if", IFX);
    zero = 1'b0;
    tick(); tick(); chk("beq_not_taken", e(1,0,0,2'b00,0,0,0,1,3'b001,0,0,0,2'b00));
    tick();
    op = 6'b110101;
    tick(); tick(); chk("bne_taken", e(1,0,0,2'b00,0,0,0,1,3'b001,0,0,0,2'b01));
    tick();
    op = 6'b110110; sign = 1'b1;
    tick(); tick(); chk("bltz_taken", e(1,0,0,2'b00,0,0,0,0,3'b001,0,0,0,2'b01));
    tick(); chk("bltz_next_if", IFX);
    sign = 1'b0;

    // jumps complete in ID
    op = 6'b111000;
    tick(); chk("j_id", e(1,0,0,2'b00,0,0,0,0,3'b000,0,0,0,2'b11));
    tick(); chk("j_next_if", IFX);
    op = 6'b111001;
    tick(); chk("jr_id", e(1,0,0,2'b00,0,0,0,0,3'b000,0,0,0,2'b10));
    tick();

    // illegal opcode: 2-cycle no-op
    op = 6'b101010;
    tick(); chk("illegal_id", e(1,0,0,2'b00,0,0,0,0,3'b000,0,0,0,2'b00));
    tick(); chk("illegal_next_if", IFX);

    // jal
    op = 6'b111010;
    tick();
`ifdef MC_JAL_EN
    chk("jal_id", e(1,0,1,2'b00,0,0,0,0,3'b000,0,0,0,2'b11));
`else
    chk("jal_id", e(1,0,0,2'b00,0,0,0,0,3'b000,0,0,0,2'b00));
`endif
    tick(); chk("jal_next_if", IFX);

    // reset held two cycles in the middle of EXE_AL
    op = 6'b010010;
    tick(); tick(); chk("rst_pre_exe", e(0,0,0,2'b00,0,0,1,0,3'b011,0,0,0,2'b00));
    Reset = 1'b0; #1;
    chk("rst_gate_now", ZERO);
    tick(); chk("rst_gate_c1", ZERO);
    tick(); chk("rst_gate_c2", ZERO);
    Reset = 1'b1; #1;
    chk("rst_after_if", IFX);
    tick(); chk("rst_after_id", ZERO);
    tick(); tick(); chk("rst_after_wb", e(1,0,1,2'b01,1,0,1,0,3'b011,0,0,0,2'b00));
    tick();

    // halt: outputs stay low indefinitely
    op = 6'b111111;
    tick(); chk("halt_id", ZERO);
    for (int i = 0; i < 6; i++) begin
      tick(); chk("halt_hold", ZERO);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
